// File: rtl/garbage_ledger.sv
// Garbage accounting between the link layer and game logic: filters duplicate packets,
// cancels incoming garbage against local attacks, forwards the surplus and feeds insertions.
module garbage_ledger #(
  parameter int GBG_BITS     = 4,
  parameter int PENDING_MAX  = 20,
  parameter int PENDING_BITS = 5
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    game_active,
  input  logic                    rx_valid,
  input  logic                    rx_seqNum,
  input  logic [GBG_BITS-1:0]     rx_garbage,
  input  logic                    attack_valid,
  input  logic [GBG_BITS-1:0]     attack_lines,
  input  logic                    send_done,
  output logic [GBG_BITS-1:0]     send_garbage,
  output logic                    send_update,
  output logic                    insert_req,
  output logic [GBG_BITS-1:0]     insert_lines,
  input  logic                    insert_ack,
  output logic [PENDING_BITS-1:0] pending,
  output logic                    overflow
);

  localparam int SUM_BITS = ((PENDING_BITS > GBG_BITS) ? PENDING_BITS : GBG_BITS) + 1;
  localparam logic [GBG_BITS-1:0] GBG_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_WAIT} send_state_t;
  typedef enum logic {I_IDLE, I_REQ} ins_state_t;

  send_state_t send_state, send_next;
  ins_state_t  ins_state, ins_next;

  logic [GBG_BITS-1:0] out_acc, acc_next, send_garbage_q, lines_cap;
  logic                last_seq, rx_accept, pend_over;
  logic [SUM_BITS-1:0] pend_ext, ack_take, reserved, p1, free_lines, attack_ext;
  logic [SUM_BITS-1:0] cancel, p2, spill, acc_base, acc_sum, pend_sum;
  logic [PENDING_BITS-1:0] pend_next;

  // Lines already latched for insertion are reserved and cannot be cancelled by attacks.
  always_comb begin
    pend_ext   = SUM_BITS'(pending);
    ack_take   = (ins_state == I_REQ && insert_ack)  ? SUM_BITS'(insert_lines) : '0;
    reserved   = (ins_state == I_REQ && !insert_ack) ? SUM_BITS'(insert_lines) : '0;
    p1         = (pend_ext > ack_take) ? pend_ext - ack_take : '0;
    free_lines = (p1 > reserved) ? p1 - reserved : '0;
    attack_ext = attack_valid ? SUM_BITS'(attack_lines) : '0;
    cancel     = (attack_ext < free_lines) ? attack_ext : free_lines;
    p2         = p1 - cancel;
    spill      = attack_ext - cancel;
    acc_base   = (send_state == S_LATCH) ? '0 : SUM_BITS'(out_acc);
    acc_sum    = acc_base + spill;
    acc_next   = (acc_sum > SUM_BITS'(GBG_MAX)) ? GBG_MAX : acc_sum[GBG_BITS-1:0];
    rx_accept  = rx_valid && (rx_seqNum != last_seq);
    pend_sum   = p2 + (rx_accept ? SUM_BITS'(rx_garbage) : '0);
    pend_over  = pend_sum > SUM_BITS'(PENDING_MAX);
    pend_next  = pend_over ? PENDING_BITS'(PENDING_MAX) : pend_sum[PENDING_BITS-1:0];
    lines_cap  = (pend_ext > SUM_BITS'(GBG_MAX)) ? GBG_MAX : pend_ext[GBG_BITS-1:0];
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      send_state <= S_IDLE;
      ins_state  <= I_IDLE;
    end else begin
      send_state <= send_next;
      ins_state  <= ins_next;
    end
  end

  always_comb begin
    send_next = send_state;
    case (send_state)
      S_IDLE:  if (out_acc != '0) send_next = S_LATCH;
      S_LATCH: send_next = S_WAIT;
      S_WAIT:  if (send_done) send_next = S_IDLE;
      default: send_next = S_IDLE;
    endcase
    ins_next = ins_state;
    if (ins_state == I_IDLE) begin
      if (pending != '0) ins_next = I_REQ;
    end else if (insert_ack) begin
      ins_next = I_IDLE;
    end
    if (!game_active) begin
      send_next = S_IDLE;
      ins_next  = I_IDLE;
    end
  end

  // The value being latched is shown on send_garbage during the update pulse itself.
  always_comb begin
    send_update  = (send_state == S_LATCH) && game_active;
    send_garbage = (send_state == S_LATCH) ? out_acc : send_garbage_q;
    insert_req   = (ins_state == I_REQ);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pending        <= '0;
      overflow       <= 1'b0;
      out_acc        <= '0;
      last_seq       <= 1'b1;
      send_garbage_q <= '0;
      insert_lines   <= '0;
    end else if (!game_active) begin
      pending        <= '0;
      overflow       <= 1'b0;
      out_acc        <= '0;
      last_seq       <= 1'b1;
      send_garbage_q <= '0;
      insert_lines   <= '0;
    end else begin
      pending  <= pend_next;
      overflow <= overflow | pend_over;
      out_acc  <= acc_next;
      if (rx_accept) last_seq <= rx_seqNum;
      if (send_state == S_LATCH) send_garbage_q <= out_acc;
      else if (send_state == S_WAIT && send_done) send_garbage_q <= '0;
      if (ins_state == I_IDLE && pending != '0) insert_lines <= lines_cap;
    end
  end

endmodule

// File: tb/tb_garbage_ledger.sv
// Self-checking bench for garbage_ledger: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural ledger model.
module tb_garbage_ledger;
  localparam int GBG_BITS     = 4;
  localparam int PENDING_MAX  = 20;
  localparam int PENDING_BITS = 5;
  localparam int GBG_MAX      = (1 << GBG_BITS) - 1;

  logic clk = 1'b0;
  logic rst_l, game_active, rx_valid, rx_seqNum, attack_valid, send_done, insert_ack;
  logic [GBG_BITS-1:0] rx_garbage, attack_lines, send_garbage, insert_lines;
  logic send_update, insert_req, overflow;
  logic [PENDING_BITS-1:0] pending;

  int checks = 0;
  int errors = 0;

  int m_pending, m_acc, m_held, m_lines;
  bit m_seq, m_ovf, m_req, m_latching, m_waiting;

  garbage_ledger #(.GBG_BITS(GBG_BITS), .PENDING_MAX(PENDING_MAX), .PENDING_BITS(PENDING_BITS)) dut (
    .clk(clk), .rst_l(rst_l), .game_active(game_active),
    .rx_valid(rx_valid), .rx_seqNum(rx_seqNum), .rx_garbage(rx_garbage),
    .attack_valid(attack_valid), .attack_lines(attack_lines), .send_done(send_done),
    .send_garbage(send_garbage), .send_update(send_update),
    .insert_req(insert_req), .insert_lines(insert_lines), .insert_ack(insert_ack),
    .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_pending = 0; m_acc = 0; m_held = 0; m_lines = 0;
    m_seq = 1'b1; m_ovf = 1'b0; m_req = 1'b0; m_latching = 1'b0; m_waiting = 1'b0;
  endtask

  // One clock of the ledger rules, evaluated on the inputs the DUT will sample next edge.
  task automatic modelStep();
    int take, p1, reserve, free_l, c, p2, spill, acc, rx, sum;
    if (!game_active) begin
      modelReset();
      return;
    end
    take    = (m_req && insert_ack) ? m_lines : 0;
    p1      = (m_pending > take) ? m_pending - take : 0;
    reserve = (m_req && !insert_ack) ? m_lines : 0;
    free_l  = (p1 > reserve) ? p1 - reserve : 0;
    c       = attack_valid ? ((int'(attack_lines) < free_l) ? int'(attack_lines) : free_l) : 0;
    p2      = p1 - c;
    spill   = attack_valid ? int'(attack_lines) - c : 0;
    acc     = (m_latching ? 0 : m_acc) + spill;
    if (acc > GBG_MAX) acc = GBG_MAX;
    rx = 0;
    if (rx_valid && (rx_seqNum != m_seq)) begin
      rx = int'(rx_garbage);
      m_seq = rx_seqNum;
    end
    sum = p2 + rx;
    if (m_latching) begin
      m_held = m_acc; m_latching = 1'b0; m_waiting = 1'b1;
    end else if (m_waiting) begin
      if (send_done) begin m_waiting = 1'b0; m_held = 0; end
    end else if (m_acc > 0) begin
      m_latching = 1'b1;
    end
    if (m_req) begin
      if (insert_ack) m_req = 1'b0;
    end else if (m_pending > 0) begin
      m_req = 1'b1;
      m_lines = (m_pending > GBG_MAX) ? GBG_MAX : m_pending;
    end
    m_acc = acc;
    if (sum > PENDING_MAX) begin
      m_ovf = 1'b1; m_pending = PENDING_MAX;
    end else begin
      m_pending = sum;
    end
  endtask

  task automatic checkOutput();
    check("send_update", int'(send_update), int'(m_latching && game_active));
    check("send_garbage", int'(send_garbage), m_latching ? m_acc : m_held);
    check("insert_req", int'(insert_req), int'(m_req));
    if (m_req) check("insert_lines", int'(insert_lines), m_lines);
    check("pending", int'(pending), m_pending);
    check("overflow", int'(overflow), int'(m_ovf));
  endtask

  always @(negedge clk) begin
    if (!rst_l) modelReset();
    checkOutput();
    if (rst_l) modelStep();
  end

  task automatic applyStimulus(input bit rxv, input bit seq, input int gbg,
                               input bit atv, input int atl, input bit done, input bit ack);
    rx_valid = rxv; rx_seqNum = seq; rx_garbage = GBG_BITS'(gbg);
    attack_valid = atv; attack_lines = GBG_BITS'(atl);
    send_done = done; insert_ack = ack;
    @(posedge clk); #1;
    rx_valid = 1'b0; attack_valid = 1'b0; send_done = 1'b0; insert_ack = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic restartGame();
    game_active = 1'b0;
    idle();
    game_active = 1'b1;
  endtask

  initial begin
    rst_l = 1'b0; game_active = 1'b0;
    rx_valid = 1'b0; rx_seqNum = 1'b0; rx_garbage = '0;
    attack_valid = 1'b0; attack_lines = '0; send_done = 1'b0; insert_ack = 1'b0;
    @(posedge clk); #1;
    check("rst pending", int'(pending), 0);
    check("rst insert_req", int'(insert_req), 0);
    check("rst insert_lines", int'(insert_lines), 0);
    check("rst send_garbage", int'(send_garbage), 0);
    @(posedge clk); #1;
    rst_l = 1'b1; game_active = 1'b1;
    idle();

    // New packet becomes pending, then is offered and acknowledged.
    applyStimulus(1, 0, 3, 0, 0, 0, 0);
    check("t1 pending", int'(pending), 3);
    idle();
    check("t1 insert_req", int'(insert_req), 1);
    check("t1 insert_lines", int'(insert_lines), 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    check("t1 ack pending", int'(pending), 0);
    check("t1 ack req", int'(insert_req), 0);

    // Duplicate sequence bit is dropped.
    applyStimulus(1, 1, 4, 0, 0, 0, 0);
    applyStimulus(1, 1, 4, 0, 0, 0, 0);
    check("t3 dup pending", int'(pending), 4);
    applyStimulus(1, 0, 2, 0, 0, 0, 0);
    check("t3 pending", int'(pending), 6);

    // Cancellation around latched lines, surplus forwarded to the sender.
    restartGame();
    applyStimulus(1, 0, 5, 0, 0, 0, 0);
    idle();
    applyStimulus(1, 1, 7, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 2, 0, 0);
    check("t2 cancel pending", int'(pending), 10);
    check("t2 no update", int'(send_update), 0);
    applyStimulus(0, 0, 0, 1, 9, 0, 0);
    check("t2 pending", int'(pending), 5);
    check("t2 update early", int'(send_update), 0);
    idle();
    check("t2 update", int'(send_update), 1);
    check("t2 send_garbage", int'(send_garbage), 4);
    idle();
    applyStimulus(0, 0, 0, 1, 5, 0, 0);
    check("t5 hold garbage", int'(send_garbage), 4);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    check("t5 done clear", int'(send_garbage), 0);
    idle();
    check("t5 relatch update", int'(send_update), 1);
    check("t5 relatch garbage", int'(send_garbage), 5);

    // Ack, attack and rx together.
    restartGame();
    applyStimulus(1, 0, 3, 0, 0, 0, 0);
    idle();
    applyStimulus(1, 1, 5, 0, 0, 0, 0);
    check("t6 pending8", int'(pending), 8);
    applyStimulus(1, 0, 2, 1, 4, 0, 1);
    check("t6 pending", int'(pending), 3);
    idle();
    check("t6 no update", int'(send_update), 0);

    // Saturation and clearing by game_active.
    restartGame();
    applyStimulus(1, 0, 15, 0, 0, 0, 0);
    idle();
    applyStimulus(1, 1, 3, 0, 0, 0, 0);
    applyStimulus(1, 0, 7, 0, 0, 0, 0);
    check("t4 sat pending", int'(pending), 20);
    check("t4 overflow", int'(overflow), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    check("t4 ack pending", int'(pending), 5);
    check("t4 overflow sticky", int'(overflow), 1);
    restartGame();
    check("t4 clr pending", int'(pending), 0);
    check("t4 clr overflow", int'(overflow), 0);

    // Asynchronous reset while the sender is waiting.
    applyStimulus(1, 0, 6, 1, 3, 0, 0);
    idle();
    idle();
    check("rst-wait garbage", int'(send_garbage), 3);
    rst_l = 1'b0;
    #2;
    check("async send_garbage", int'(send_garbage), 0);
    check("async pending", int'(pending), 0);
    check("async insert_req", int'(insert_req), 0);
    @(posedge clk); #1;
    rst_l = 1'b1;
    idle();

    for (int i = 0; i < 3000; i++) begin
      game_active = ($urandom_range(0, 149) != 0);
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, GBG_MAX),
                    $urandom_range(0, 4) == 0, $urandom_range(0, GBG_MAX),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end
    game_active = 1'b1;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/garbage_ledger.md
Name: garbage_ledger

Overview:
- Garbage accounting stage between the link layer (receiver/sender) and game logic.
- Consumes receiver packets carrying the opponent's garbage count.
- Cancels incoming garbage against local line-clear attacks and forwards any uncancelled attack to the sender as the outgoing garbage field.
- Hands pending garbage to the playfield logic through a req/ack insertion handshake.

Parameters:
GBG_BITS, 4, width of the garbage field in a packet and of one attack/insertion quantity
PENDING_MAX, 20, saturation ceiling of the pending-garbage counter
PENDING_BITS, 5, width of the pending counter; must hold PENDING_MAX

Ports:
clk  in  1  system clock
rst_l  in  1  asynchronous active-low reset
game_active  in  1  high while a game is in progress; low clears all state
rx_valid  in  1  one-cycle pulse, receiver delivered a game packet
rx_seqNum  in  1  sequence bit of the delivered packet
rx_garbage  in  GBG_BITS  garbage lines the opponent sent
attack_valid  in  1  one-cycle pulse, local line clear generated an attack
attack_lines  in  GBG_BITS  attack size
send_done  in  1  one-cycle pulse, sender finished transmitting the last requested packet
send_garbage  out  GBG_BITS  garbage field for the sender; held stable in S_WAIT
send_update  out  1  one-cycle pulse requesting the sender to transmit
insert_req  out  1  pending garbage is ready to be inserted
insert_lines  out  GBG_BITS  lines to insert; stable while insert_req is high
insert_ack  in  1  playfield consumed insert_lines this cycle
pending  out  PENDING_BITS  current pending incoming garbage
overflow  out  1  sticky; pending saturated at least once this game

Behaviour:
- Reset (async, rst_l=0) sets:
  - send_garbage=0, send_update=0, insert_req=0, insert_lines=0, pending=0, overflow=0.
  - Internal out_acc=0, last_seq=1. Both FSMs go to IDLE.
- game_active=0 applies the same values synchronously on the next edge. It overrides every other input.
- Duplicate filter:
  - rx_valid is accepted only if rx_seqNum != last_seq. On accept, last_seq<=rx_seqNum.
  - A rejected (retransmitted) packet changes nothing.
- Per-cycle pending update, in this order, all combinational from registered state:
  - p1 = pending - (insert_ack & insert_req ? insert_lines : 0).
  - free = p1 - (insert FSM in I_REQ and no ack ? insert_lines : 0). Latched lines cannot be cancelled.
  - c = min(attack_lines, free) when attack_valid, else 0.
  - p2 = p1 - c.
  - out_acc += attack_lines - c, saturating at 2^GBG_BITS-1.
  - pending <= min(p2 + accepted rx_garbage, PENDING_MAX).
  - overflow <= 1 if the sum exceeded PENDING_MAX.
- Send FSM:
  - S_IDLE: go to S_LATCH if out_acc>0.
  - S_LATCH (1 cycle): send_garbage<=out_acc, out_acc<=0 (an attack arriving this cycle lands in the cleared accumulator), send_update pulses. Next state S_WAIT.
  - S_WAIT: hold send_garbage. On send_done go to S_IDLE and clear send_garbage to 0. Attacks keep accumulating into out_acc.
  - send_done outside S_WAIT is ignored.
  - Latency: attack_valid at cycle N gives send_update at N+2.
- Insert FSM:
  - I_IDLE: if pending>0, go to I_REQ. insert_lines<=min(pending, 2^GBG_BITS-1), insert_req<=1.
  - I_REQ: hold both outputs. On insert_ack, subtract as above, drop insert_req, go to I_IDLE. A re-request takes at least one idle cycle.
- Simultaneous rx, attack and ack in one cycle: all three apply per the ordering above.
- game_active falling mid-handshake: both FSMs abort to IDLE with no pulses.

Test Plan:
1. rx_valid seq=0 garbage=3, no attacks -> pending=3 next cycle. Then insert_req=1, insert_lines=3. Ack -> pending=0, insert_req=0.
2. pending=5 (unlatched), attack_lines=2 -> pending=3, no send_update. Then attack_lines=6 with pending=3 -> pending=0, out_acc=3, send_update 2 cycles later with send_garbage=3.
3. Two rx_valid with seq=1 garbage=4 -> second rejected, pending=4. A third with seq=0 garbage=2 -> pending=6.
4. pending=18, rx garbage=7 -> pending=20, overflow=1 and remains set. game_active=0 -> everything cleared, overflow=0.
5. In S_WAIT with send_garbage=2, attack 5 arrives -> send_garbage stays 2. send_done -> IDLE, then LATCH with send_garbage=5.
6. Same cycle: insert_ack (lines=3, pending=8), attack 4, rx garbage 2 -> pending=3, out_acc=0. Also assert rst_l low mid-S_WAIT -> immediate reset values.
